// File: rtl/comp_share_arb.sv
// Round-robin arbiter sharing one equality comparator among NREQ requesters.
// Optional response counters (Cmp_cnt, Match_cnt): define COMP_ARB_STATS_EN.
module comp_share_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Rstn,
  input  logic [NREQ-1:0]       Req_valid,
  output logic [NREQ-1:0]       Req_ready,
  input  logic [NREQ*WIDTH-1:0] Req_a,
  input  logic [NREQ*WIDTH-1:0] Req_b,
  output logic                  Rsp_valid,
  input  logic                  Rsp_ready,
  output logic                  Rsp_z,
  output logic [IDW-1:0]        Rsp_id
`ifdef COMP_ARB_STATS_EN
  ,
  output logic [15:0]           Cmp_cnt,
  output logic [15:0]           Match_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RSP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_z_q, rsp_z_d;
  logic             cmp_z;
  logic             found;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   idx;
  int               sum;

  Comp #(.WIDTH(WIDTH)) u_comp (
    .a_i (r1_q),
    .b_i (r2_q),
    .z_o (cmp_z)
  );

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    sum   = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!found && Req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;
    Req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          Req_ready[gnt] = Rstn;
          r1_d    = Req_a[gnt*WIDTH +: WIDTH];
          r2_d    = Req_b[gnt*WIDTH +: WIDTH];
          gid_d   = gnt;
          state_d = CMP;
        end
      end
      CMP: begin
        rsp_z_d     = cmp_z;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (Rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign Rsp_valid = rsp_valid_q;
  assign Rsp_z     = rsp_z_q;
  assign Rsp_id    = rsp_id_q;

`ifdef COMP_ARB_STATS_EN
  logic [15:0] cmp_cnt_q;
  logic [15:0] match_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      cmp_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else if (state_q == RSP && Rsp_ready) begin
      cmp_cnt_q <= cmp_cnt_q + 16'd1;
      if (rsp_z_q) match_cnt_q <= match_cnt_q + 16'd1;
    end
  end

  assign Cmp_cnt   = cmp_cnt_q;
  assign Match_cnt = match_cnt_q;
`endif

endmodule

module Comp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             z_o
);
  assign z_o = (a_i == b_i);
endmodule

// File: tb/tb_comp_share_arb.sv
// Directed and random checks for comp_share_arb (NREQ=4, WIDTH=8).
// Stats ports are exercised when COMP_ARB_STATS_EN is defined.
module tb_comp_share_arb;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  Clk = 1'b0;
  logic                  Rstn;
  logic [NREQ-1:0]       Req_valid;
  logic [NREQ-1:0]       Req_ready;
  logic [NREQ*WIDTH-1:0] Req_a;
  logic [NREQ*WIDTH-1:0] Req_b;
  logic                  Rsp_valid;
  logic                  Rsp_ready;
  logic                  Rsp_z;
  logic [IDW-1:0]        Rsp_id;
`ifdef COMP_ARB_STATS_EN
  logic [15:0]           Cmp_cnt;
  logic [15:0]           Match_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  logic [7:0] av [NREQ];
  logic [7:0] bv [NREQ];

  comp_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .Clk       (Clk),
    .Rstn      (Rstn),
    .Req_valid (Req_valid),
    .Req_ready (Req_ready),
    .Req_a     (Req_a),
    .Req_b     (Req_b),
    .Rsp_valid (Rsp_valid),
    .Rsp_ready (Rsp_ready),
    .Rsp_z     (Rsp_z),
    .Rsp_id    (Rsp_id)
`ifdef COMP_ARB_STATS_EN
    ,
    .Cmp_cnt   (Cmp_cnt),
    .Match_cnt (Match_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      Req_a[i*WIDTH +: WIDTH] = av[i];
      Req_b[i*WIDTH +: WIDTH] = bv[i];
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Rstn = 1'b0;
    Req_valid = '0;
    Rsp_ready = 1'b1;
    step();
    step();
    Rstn = 1'b1;
  endtask

  task automatic test_reset();
    Rstn = 1'b0;
    Req_valid = 4'hF;
    Rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = 8'h11;
      bv[i] = 8'h11;
    end
    drive_ops();
    step();
    step();
    checks++;
    if (Req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0000", Req_ready);
    end
    checks++;
    if (Rsp_valid !== 1'b0 || Rsp_z !== 1'b0 || Rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_rsp: got v=%b z=%b id=%0d want 0 0 0",
               Rsp_valid, Rsp_z, Rsp_id);
    end
`ifdef COMP_ARB_STATS_EN
    checks++;
    if (Cmp_cnt !== 16'd0 || Match_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d %0d want 0 0", Cmp_cnt, Match_cnt);
    end
`endif
    Rstn = 1'b1;
    Req_valid = '0;
    #1;
    checks++;
    if (Req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL idle_noreq: got %b want 0000", Req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    av[0] = 8'hAA;
    bv[0] = 8'hAA;
    drive_ops();
    Req_valid = 4'b0001;
    #1;
    checks++;
    if (Req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_grant: got %b want 0001", Req_ready);
    end
    step();
    Req_valid = '0;
    #1;
    checks++;
    if (Req_ready !== 4'b0000 || Rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_cmp: got rdy=%b v=%b want 0000 0",
               Req_ready, Rsp_valid);
    end
    step();
    checks++;
    if (Rsp_valid !== 1'b1 || Rsp_z !== 1'b1 || Rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL single_rsp: got v=%b z=%b id=%0d want 1 1 0",
               Rsp_valid, Rsp_z, Rsp_id);
    end
    step();
    checks++;
    if (Rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_clear: got v=%b want 0", Rsp_valid);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    av[2] = 8'hF0;
    bv[2] = 8'h80;
    drive_ops();
    Req_valid = 4'b0100;
    #1;
    checks++;
    if (Req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL mis_grant: got %b want 0100", Req_ready);
    end
    step();
    Req_valid = '0;
    step();
    checks++;
    if (Rsp_valid !== 1'b1 || Rsp_z !== 1'b0 || Rsp_id !== 2'd2) begin
      fails++;
      $display("FAIL mis_rsp: got v=%b z=%b id=%0d want 1 0 2",
               Rsp_valid, Rsp_z, Rsp_id);
    end
    step();
`ifdef COMP_ARB_STATS_EN
    checks++;
    if (Cmp_cnt !== 16'd1 || Match_cnt !== 16'd0) begin
      fails++;
      $display("FAIL mis_cnt: got %0d %0d want 1 0", Cmp_cnt, Match_cnt);
    end
`endif
    checks++;
    if (Rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mis_clear: got v=%b want 0", Rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      av[i] = 8'hEA;
      bv[i] = 8'hEA;
    end
    drive_ops();
    Req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_id  = 2'(k % NREQ);
      exp_rdy = 4'b0001 << exp_id;
      #1;
      checks++;
      if (Req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL rr_grant%0d: got %b want %b", k, Req_ready, exp_rdy);
      end
      step();
      checks++;
      if (Req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL rr_cmp%0d: got %b want 0000", k, Req_ready);
      end
      step();
      checks++;
      if (Rsp_valid !== 1'b1 || Rsp_z !== 1'b1 || Rsp_id !== exp_id) begin
        fails++;
        $display("FAIL rr_rsp%0d: got v=%b z=%b id=%0d want 1 1 %0d",
                 k, Rsp_valid, Rsp_z, Rsp_id, exp_id);
      end
      step();
    end
`ifdef COMP_ARB_STATS_EN
    checks++;
    if (Cmp_cnt !== 16'd5 || Match_cnt !== 16'd5) begin
      fails++;
      $display("FAIL rr_cnt: got %0d %0d want 5 5", Cmp_cnt, Match_cnt);
    end
`endif
    Req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    av[1] = 8'h3C;
    bv[1] = 8'h3D;
    drive_ops();
    Req_valid = 4'b0010;
    Rsp_ready = 1'b0;
    #1;
    checks++;
    if (Req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL bp_grant: got %b want 0010", Req_ready);
    end
    step();
    step();
    Req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (Rsp_valid !== 1'b1 || Rsp_z !== 1'b0 || Rsp_id !== 2'd1 ||
          Req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b z=%b id=%0d rdy=%b want 1 0 1 0000",
                 c, Rsp_valid, Rsp_z, Rsp_id, Req_ready);
      end
      step();
    end
    Rsp_ready = 1'b1;
    step();
    #1;
    checks++;
    if (Req_ready !== 4'b0100 || Rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_next: got rdy=%b v=%b want 0100 0", Req_ready, Rsp_valid);
    end
    Req_valid = '0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    av[1] = 8'h01;
    bv[1] = 8'h01;
    drive_ops();
    Req_valid = 4'b0010;
    step();
    Req_valid = '0;
    step();
    step();
    av[0] = 8'h07;
    bv[0] = 8'h07;
    av[3] = 8'h09;
    bv[3] = 8'h09;
    drive_ops();
    Req_valid = 4'b1001;
    #1;
    checks++;
    if (Req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL mid_pre: got %b want 1000", Req_ready);
    end
    step();
    Rstn = 1'b0;
    #1;
    checks++;
    if (Req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL mid_rstrdy: got %b want 0000", Req_ready);
    end
    step();
    checks++;
    if (Rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_drop: got v=%b want 0", Rsp_valid);
    end
    Rstn = 1'b1;
    #1;
    checks++;
    if (Req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL mid_ptr: got %b want 0001", Req_ready);
    end
    step();
    Req_valid = '0;
    checks++;
    if (Rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_cmp: got v=%b want 0", Rsp_valid);
    end
    step();
    checks++;
    if (Rsp_valid !== 1'b1 || Rsp_id !== 2'd0 || Rsp_z !== 1'b1) begin
      fails++;
      $display("FAIL mid_rsp: got v=%b z=%b id=%0d want 1 1 0",
               Rsp_valid, Rsp_z, Rsp_id);
    end
    step();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    int mptr;
    int g;
    int j;
    int maxw;
    int waits [NREQ];
    logic ez;
    logic [3:0] exp_rdy;
    do_reset();
    pend = '0;
    mptr = 0;
    maxw = 0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          av[i] = 8'($urandom);
          bv[i] = ($urandom_range(0, 1) == 1) ? av[i] : 8'($urandom);
        end
      end
      if (pend == '0) begin
        j = $urandom_range(0, NREQ - 1);
        pend[j] = 1'b1;
        av[j] = 8'($urandom);
        bv[j] = 8'($urandom);
      end
      drive_ops();
      Req_valid = pend;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (g < 0 && pend[j]) g = j;
      end
      exp_rdy = 4'b0001 << g;
      ez = (av[g] == bv[g]);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && i != g) begin
          waits[i]++;
          if (waits[i] > maxw) maxw = waits[i];
        end
      end
      waits[g] = 0;
      #1;
      checks++;
      if (Req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL rnd_grant%0d: got %b want %b", it, Req_ready, exp_rdy);
      end
      step();
      pend[g] = 1'b0;
      Req_valid = pend;
      step();
      checks++;
      if (Rsp_valid !== 1'b1 || Rsp_z !== ez || Rsp_id !== 2'(g)) begin
        fails++;
        $display("FAIL rnd_rsp%0d: got v=%b z=%b id=%0d want 1 %b %0d",
                 it, Rsp_valid, Rsp_z, Rsp_id, ez, g);
      end
      step();
      mptr = (g + 1) % NREQ;
    end
    checks++;
    if (maxw >= NREQ) begin
      fails++;
      $display("FAIL rnd_starve: got max wait %0d want < %0d", maxw, NREQ);
    end
    Req_valid = '0;
  endtask

  initial begin
    Rstn = 1'b0;
    Req_valid = '0;
    Rsp_ready = 1'b0;
    Req_a = '0;
    Req_b = '0;
    test_reset();
    test_single();
    test_mismatch();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
